// File: rtl/mul_shift_add.sv
// Sequential 16x16 unsigned shift-and-add multiplier with valid/ready handshakes.
// One partial-product add per cycle through a single 16-bit ripple adder.

module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry
);

    logic [16:0] c;

    assign c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign carry = c[16];

endmodule

module mul_shift_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [15:0] addSum;
    logic        addCarry;

    adder u_adder (
        .a     (hi_q),
        .b     (mcand_q),
        .sum   (addSum),
        .carry (addCarry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // The adder carry becomes bit 15 of the new high half, so no partial-sum bit is lost.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {addCarry, addSum, lo_q[15:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[15:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = out_valid ? {hi_q, lo_q} : 32'd0;

endmodule
